// File: rtl/uart_rx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_arbiter
//  Purpose  : Receive FIFO for UART bytes shared between two requesters with
//             round-robin arbitration, one grant pulse per delivered byte.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_arbiter #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_done_tick,
    input  logic [W-1:0]  rx_data,
    input  logic          rd_req0,
    input  logic          rd_req1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [W-1:0]  r_data,
    input  logic          clr_overrun,
    output logic          overrun,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam logic [AW:0] c_FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           r_empty;
    logic           r_full;
    logic           r_overrun;
    logic           r_gnt0;
    logic           r_gnt1;
    logic [W-1:0]   r_data_q;
    logic           r_prio;

    logic           w_pop;
    logic           w_push;
    logic           w_drop;
    logic           w_winner;
    logic [AW:0]    w_count_nxt;

    // A pop only happens from IDLE, so a full FIFO can still accept a byte
    // on the same edge that frees a slot.
    always_comb begin
        w_pop    = (r_state == S_IDLE) && !r_empty && (rd_req0 || rd_req1);
        w_push   = rx_done_tick && (!r_full || w_pop);
        w_drop   = rx_done_tick && r_full && !w_pop;
        w_winner = (rd_req0 && rd_req1) ? r_prio : rd_req1;
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + (AW+1)'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_FULL_COUNT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    // Grant FSM: the pop edge loads r_data and the grant, which then lasts
    // exactly the GRANT cycle. Priority moves away from whoever was served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_data_q <= '0;
            r_prio   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_data_q <= r_mem[r_rd_ptr];
                        r_gnt0   <= !w_winner;
                        r_gnt1   <= w_winner;
                        r_prio   <= !w_winner;
                        r_state  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign r_data  = r_data_q;
    assign overrun = r_overrun;
    assign empty   = r_empty;
    assign full    = r_full;
    assign count   = r_count;

endmodule
`default_nettype wire

// File: doc/uart_rx_arbiter.md
Name: uart_rx_arbiter

Overview:
Receive-side controller between the UART receiver and the system bus. Buffers received bytes in a small FIFO and shares them between two system requesters, using round-robin arbitration with one grant per byte. Replaces the single-entry flag buffer and its flag-polling scheme when more than one consumer reads the receive stream. Tracks overrun when bytes arrive faster than the requesters drain them.

Parameters:
W, 8, data width of a received byte
DEPTH, 4, FIFO entries; power of two, minimum 2
AW, 2, pointer width; log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
rx_done_tick  input  1  one-cycle pulse from UART receiver: byte complete
rx_data  input  W  received byte, valid while rx_done_tick=1
rd_req0  input  1  requester 0 wants a byte (level)
rd_req1  input  1  requester 1 wants a byte (level)
gnt0  output  1  one-cycle pulse: r_data belongs to requester 0
gnt1  output  1  one-cycle pulse: r_data belongs to requester 1
r_data  output  W  byte delivered with the grant
clr_overrun  input  1  clears sticky overrun flag
overrun  output  1  sticky: a byte was dropped because the FIFO was full
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds DEPTH entries
count  output  AW+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (reset=0, asynchronous): FIFO pointers and count = 0; empty=1; full=0; overrun=0; gnt0=gnt1=0; r_data=0; state=IDLE; round-robin priority = requester 0.
- Push: rx_done_tick=1 and FIFO not full → rx_data written at wr_ptr, wr_ptr+1 (wraps modulo DEPTH), count+1.
- Push while full: byte dropped; overrun set next edge. The exception is a pop at the same edge: then the push is accepted and count stays DEPTH.
- Overrun: set takes precedence over clr_overrun in the same cycle. Otherwise clr_overrun=1 → overrun=0.
- FSM, two states:
  - IDLE: if !empty and (rd_req0 | rd_req1), pick a winner, pop the head into the r_data register, rd_ptr+1, → GRANT. Otherwise stay in IDLE.
  - GRANT: gnt of the winner = 1 for exactly this cycle; r_data holds the popped byte; → IDLE unconditionally.
- Throughput: at most one byte every 2 cycles. Request to grant latency is 1 cycle: req sampled at edge N, gnt high in cycle N+1.
- Arbitration:
  - Only one requester active → it wins.
  - Both active → the requester holding priority wins, and priority passes to the other requester.
  - Priority changes only when a grant is issued.
- gnt0 and gnt1 are never high together and are never high outside GRANT.
- r_data holds its last value until the next pop; it is only meaningful while a gnt is high.
- Requests while empty: no grant, no state change. Deasserting a request while in GRANT does not cancel the grant; the byte is already popped.
- Simultaneous push and pop with the FIFO not full or empty: both occur, count unchanged.
- Push into an empty FIFO: empty=0 the next cycle; the earliest pop is at the following edge (no write-through bypass).
- count, empty and full are registered and consistent with each other every cycle.
- Reset mid-grant: gnt drops immediately (asynchronous); buffered data is discarded.

Test Plan:
- Reset then single byte: rx_done_tick with 0xA5, rd_req0=1 → gnt0 pulses 1 cycle with r_data=0xA5 two cycles after the push edge; count 1→0; empty returns to 1.
- Fairness: push 0x11,0x22,0x33,0x44, hold rd_req0=rd_req1=1 → grants alternate gnt0(0x11), gnt1(0x22), gnt0(0x33), gnt1(0x44), one every 2 cycles; never both high.
- Overrun: with no requests, push 5 bytes 0x01..0x05 into DEPTH=4 → full=1, count=4, overrun=1, 0x05 dropped. Drain returns 0x01..0x04. Pulse clr_overrun → overrun=0.
- Full with simultaneous push/pop: FIFO full, rd_req1=1 and rx_done_tick with 0x77 on the same IDLE edge → push accepted, count stays 4, overrun stays 0, 0x77 is delivered last.
- Wrap-around: 10 push/drain cycles of alternating bytes with DEPTH=4 → output order equals input order across pointer wrap; count never exceeds 4.
- Asynchronous reset mid-operation: assert reset between clock edges while gnt1=1 with 3 entries buffered → gnt1, count and overrun go to 0 immediately; empty=1; the first grant after release goes to requester 0.
